// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//   Shares the single data_ram port between two requesters:
//     m0 = CPU MEM stage, m1 = loader/DMA.
//   Round-robin arbitration with an optional m1 burst lock (capped so m0 cannot
//   starve), one transaction every three cycles (IDLE -> SERVE -> RESP), and a
//   registered read response per requester.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   m0_req/we/addr/sel/wdata m0 request fields, held stable until m0_ack
//   m0_ack, m0_rdata         1-cycle completion pulse, registered read data
//   m0_stall                 m0_req & ~m0_ack, pipeline stall to the CPU
//   m1_req/we/addr/sel/wdata m1 request fields, held stable until m1_ack
//   m1_ack, m1_rdata         1-cycle completion pulse, registered read data
//   m1_lock                  m1 asks for back-to-back grants
//   sel_err                  pulses with ack when a write carried an illegal sel
//   ram_ce/we/addr/sel/wdata data_ram request, driven combinationally
//   ram_rdata                data_ram combinational read data
module data_ram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_sel,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_stall,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_sel,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,

  output logic              sel_err,

  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  logic             owner;      // 0 = m0, 1 = m1
  logic             last;       // most recent winner, 1 = m1
  logic [CNT_W-1:0] burst_cnt;  // locked m1 grants taken while m0 waited

  logic             grant_m1;
  logic [CNT_W-1:0] burst_nxt;

  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [3:0]        own_sel;
  logic [DATA_W-1:0] own_wdata;
  logic              legal_sel;

  // Arbitration. A locked m1 keeps the port after its own grant until the
  // burst counter reaches the cap; otherwise the last winner yields.
  always_comb begin
    grant_m1 = m1_req;
    if (m0_req && m1_req) begin
      if (last && m1_lock && (burst_cnt < BURST_CAP))
        grant_m1 = 1'b1;
      else
        grant_m1 = ~last;
    end
  end

  // The counter only advances while m0 is actually being held off; any other
  // grant (including m1 alone) clears it.
  always_comb begin
    burst_nxt = '0;
    if (grant_m1 && m1_lock && m0_req)
      burst_nxt = (burst_cnt == BURST_CAP) ? burst_cnt : burst_cnt + 1'b1;
  end

  // Request fields come live from the owner; the protocol keeps them stable
  // until ack, so no copy is registered.
  always_comb begin
    own_we    = owner ? m1_we    : m0_we;
    own_addr  = owner ? m1_addr  : m0_addr;
    own_sel   = owner ? m1_sel   : m0_sel;
    own_wdata = owner ? m1_wdata : m0_wdata;
  end

  assign legal_sel = (own_sel == 4'b0100) || (own_sel == 4'b0010) ||
                     (own_sel == 4'b0001);

  // Chip enable is gated by reset so a reset landing in SERVE cannot commit.
  assign ram_ce    = rst && (state == SERVE);
  assign ram_we    = ram_ce && own_we && legal_sel;
  assign ram_addr  = own_addr;
  assign ram_sel   = own_sel;
  assign ram_wdata = own_wdata;

  assign m0_stall  = m0_req & ~m0_ack;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      burst_cnt <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      sel_err   <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;
      sel_err <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner     <= grant_m1;
            last      <= grant_m1;
            burst_cnt <= burst_nxt;
            state     <= SERVE;
          end
        end
        SERVE: begin
          // Reads always capture the full word, even with an illegal sel.
          if (!own_we) begin
            if (owner)
              m1_rdata <= ram_rdata;
            else
              m0_rdata <= ram_rdata;
          end
          if (owner)
            m1_ack <= 1'b1;
          else
            m0_ack <= 1'b1;
          sel_err <= own_we && !legal_sel;
          state   <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter
//   Directed bench for data_ram_arbiter with a behavioural byte-addressed
//   data_ram behind it. Expected acks are queued when a request is driven and
//   matched in order against the acks the arbiter produces.
module tb_data_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m1_ack, m0_stall, sel_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  localparam logic [3:0] WORD = 4'b0100;
  localparam logic [3:0] HALF = 4'b0010;
  localparam logic [3:0] BYTE = 4'b0001;

  typedef struct {
    logic        m;
    logic        chk;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  data_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_lock(m1_lock),
    .sel_err(sel_err),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte-addressed RAM model; words 16/17 (0x40/0x44) carry a
  // fixed image that is restored whenever reset is held.
  logic [31:0] mem [0:63];
  logic [5:0]  idx;
  assign idx       = ram_addr[7:2];
  assign ram_rdata = mem[idx];

  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      case (ram_sel)
        WORD: mem[idx] <= ram_wdata;
        HALF: begin
          if (ram_addr[1]) mem[idx][31:16] <= ram_wdata[15:0];
          else             mem[idx][15:0]  <= ram_wdata[15:0];
        end
        BYTE: mem[idx][{ram_addr[1:0], 3'b000} +: 8] <= ram_wdata[7:0];
        default: ;
      endcase
    end
    if (!rst) begin
      mem[16] <= 32'h0A0A0A0A;
      mem[17] <= 32'h1B1B1B1B;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expectAck(input logic m, input logic chk, input logic [31:0] rd, input logic err);
    exp_t e;
    e.m = m; e.chk = chk; e.rd = rd; e.err = err;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic m, input logic we, input logic [31:0] addr,
                               input logic [3:0] sel, input logic [31:0] wdata);
    if (m) begin
      m1_we = we; m1_addr = addr; m1_sel = sel; m1_wdata = wdata; m1_req = 1'b1;
    end else begin
      m0_we = we; m0_addr = addr; m0_sel = sel; m0_wdata = wdata; m0_req = 1'b1;
    end
  endtask

  task automatic releaseReq(input logic drop0, input logic drop1);
    if (drop0) m0_req = 1'b0;
    if (drop1) m1_req = 1'b0;
    tick();
    tick();
  endtask

  // Called on a cycle where an ack is visible: match it to the oldest entry.
  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("[TB] FAIL sb_underflow: observed ack m0=%0d m1=%0d expected none", m0_ack, m1_ack);
      return;
    end
    e = sb.pop_front();
    checkVal("ack_master", {31'd0, m1_ack}, {31'd0, e.m});
    checkVal("ack_onehot", {31'd0, m0_ack & m1_ack}, 32'd0);
    if (e.chk) checkVal("rdata", e.m ? m1_rdata : m0_rdata, e.rd);
    checkVal("sel_err", {31'd0, sel_err}, {31'd0, e.err});
    checkVal("m0_stall", {31'd0, m0_stall}, {31'd0, m0_req & ~m0_ack});
  endtask

  task automatic collectAcks(input int n, input int budget);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      tick();
      cyc++;
      if (m0_ack || m1_ack) begin
        checkOutput();
        seen++;
      end
    end
    checks++;
    assert (seen == n) else begin
      errors++;
      $error("[TB] FAIL ack_count: observed %0d expected %0d", seen, n);
    end
  endtask

  task automatic doTxn(input logic m, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wdata,
                       input logic chk, input logic [31:0] rd, input logic err);
    expectAck(m, chk, rd, err);
    applyStimulus(m, we, addr, sel, wdata);
    collectAcks(1, 10);
    releaseReq(!m, m);
  endtask

  initial begin
    rst = 1'b0; m1_lock = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_sel = WORD; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_sel = WORD; m1_wdata = '0;
    repeat (3) tick();

    // Reset state
    checkVal("rst_m0_ack",   {31'd0, m0_ack},  32'd0);
    checkVal("rst_m1_ack",   {31'd0, m1_ack},  32'd0);
    checkVal("rst_sel_err",  {31'd0, sel_err}, 32'd0);
    checkVal("rst_m0_rdata", m0_rdata, 32'd0);
    checkVal("rst_m1_rdata", m1_rdata, 32'd0);
    checkVal("rst_ram_ce",   {31'd0, ram_ce},  32'd0);
    rst = 1'b1;
    tick();

    // Both requesters from reset, held: m0, m1, m0, m1
    $display("[TB] simultaneous requests from reset");
    expectAck(1'b0, 1'b1, 32'h0A0A0A0A, 1'b0);
    expectAck(1'b1, 1'b1, 32'h1B1B1B1B, 1'b0);
    expectAck(1'b0, 1'b1, 32'h0A0A0A0A, 1'b0);
    expectAck(1'b1, 1'b1, 32'h1B1B1B1B, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h40, WORD, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h44, WORD, 32'h0);
    #1;
    checkVal("stall_waiting", {31'd0, m0_stall}, 32'd1);
    collectAcks(4, 40);
    releaseReq(1'b1, 1'b1);

    // Word write with exact latency, then readback
    $display("[TB] word write / read latency");
    expectAck(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h10, WORD, 32'hDEADBEEF);
    tick();
    checkVal("serve_ack",  {31'd0, m0_ack}, 32'd0);
    checkVal("serve_ce",   {31'd0, ram_ce}, 32'd1);
    checkVal("serve_we",   {31'd0, ram_we}, 32'd1);
    checkVal("serve_addr", ram_addr, 32'h10);
    tick();
    checkVal("resp_ack", {31'd0, m0_ack}, 32'd1);
    checkOutput();
    m0_req = 1'b0;
    tick();
    checkVal("ack_pulse", {31'd0, m0_ack}, 32'd0);
    tick();
    doTxn(1'b0, 1'b0, 32'h10, WORD, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);

    // Byte and half writes
    $display("[TB] byte / half writes");
    doTxn(1'b0, 1'b1, 32'h13, BYTE, 32'h000000AA, 1'b0, 32'h0, 1'b0);
    doTxn(1'b0, 1'b0, 32'h10, WORD, 32'h0, 1'b1, 32'hAAADBEEF, 1'b0);
    doTxn(1'b0, 1'b1, 32'h10, HALF, 32'h00001234, 1'b0, 32'h0, 1'b0);
    doTxn(1'b0, 1'b0, 32'h10, WORD, 32'h0, 1'b1, 32'hAAAD1234, 1'b0);

    // Illegal sel: write suppressed with sel_err, read returns full word
    $display("[TB] illegal sel");
    doTxn(1'b0, 1'b1, 32'h20, WORD, 32'h55667788, 1'b0, 32'h0, 1'b0);
    doTxn(1'b1, 1'b1, 32'h20, 4'b0011, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
    doTxn(1'b0, 1'b0, 32'h20, WORD, 32'h0, 1'b1, 32'h55667788, 1'b0);
    doTxn(1'b1, 1'b0, 32'h20, 4'b0011, 32'h0, 1'b1, 32'h55667788, 1'b0);

    // Burst lock: after an m0 grant, 8 locked m1 grants then m0
    $display("[TB] burst lock");
    doTxn(1'b0, 1'b0, 32'h40, WORD, 32'h0, 1'b1, 32'h0A0A0A0A, 1'b0);
    m1_lock = 1'b1;
    repeat (8) expectAck(1'b1, 1'b1, 32'h1B1B1B1B, 1'b0);
    expectAck(1'b0, 1'b1, 32'h0A0A0A0A, 1'b0);
    expectAck(1'b1, 1'b1, 32'h1B1B1B1B, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h40, WORD, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h44, WORD, 32'h0);
    collectAcks(10, 100);
    releaseReq(1'b1, 1'b1);

    // Locked m1 alone keeps winning and its counter stays clear, so a later
    // m0 request again waits a full 8 grants
    repeat (3) expectAck(1'b1, 1'b1, 32'h1B1B1B1B, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h44, WORD, 32'h0);
    collectAcks(3, 30);
    repeat (8) expectAck(1'b1, 1'b1, 32'h1B1B1B1B, 1'b0);
    expectAck(1'b0, 1'b1, 32'h0A0A0A0A, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h40, WORD, 32'h0);
    collectAcks(9, 100);
    releaseReq(1'b1, 1'b1);
    m1_lock = 1'b0;

    // Reset during SERVE of a write
    $display("[TB] reset mid-transaction");
    doTxn(1'b0, 1'b1, 32'h30, WORD, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h30, WORD, 32'h99999999);
    tick();
    checkVal("mid_ce", {31'd0, ram_ce}, 32'd1);
    rst = 1'b0;
    #1;
    checkVal("rst_gates_ce", {31'd0, ram_ce}, 32'd0);
    tick();
    checkVal("abort_m0_ack",   {31'd0, m0_ack},  32'd0);
    checkVal("abort_m1_ack",   {31'd0, m1_ack},  32'd0);
    checkVal("abort_sel_err",  {31'd0, sel_err}, 32'd0);
    checkVal("abort_m0_rdata", m0_rdata, 32'd0);
    checkVal("abort_m1_rdata", m1_rdata, 32'd0);
    m0_req = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checkVal("abort_no_ack", {31'd0, m0_ack}, 32'd0);
    doTxn(1'b0, 1'b0, 32'h30, WORD, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);

    checkVal("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
